// File: rtl/seven_segment_scanner.sv
// Time-multiplexed 3-digit seven-segment scanner with per-slot dead time.
// Optional leading-zero blanking of tens/hundreds: define LEADING_ZERO_BLANK_EN.
module seven_segment_scanner #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned DEAD_CYCLES  = 16,
    parameter logic [6:0]  ZERO_PATTERN = 7'b1000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_enable,
    input  logic [6:0] i_seg_units,
    input  logic [6:0] i_seg_tens,
    input  logic [6:0] i_seg_hunds,
    output logic [6:0] o_segments,
    output logic [2:0] o_anodes,
    output logic [1:0] o_digit_sel
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] DEAD_PHASE = PW'(DEAD_CYCLES);

    typedef enum logic [1:0] {
        SLOT_UNITS = 2'd0,
        SLOT_TENS  = 2'd1,
        SLOT_HUNDS = 2'd2
    } slot_t;

    // r_nphase/r_nslot name the phase and slot the outputs will show after the
    // next enabled edge, so reset and the first counted edge both present phase 0.
    logic [PW-1:0] r_nphase;
    slot_t         r_nslot;
    logic [6:0]    r_segments;
    logic [2:0]    r_anodes;
    logic [1:0]    r_digit_sel;

    logic [PW-1:0] w_nphase_nxt;
    slot_t         w_nslot_nxt;
    logic [6:0]    w_seg_nxt;
    logic [2:0]    w_an_nxt;
    logic [1:0]    w_sel_nxt;

    logic [6:0]    w_snap_tens;
    logic [6:0]    w_snap_hunds;

`ifdef LEADING_ZERO_BLANK_EN
    logic w_hunds_zero;
    logic w_tens_zero;

    assign w_hunds_zero = (i_seg_hunds == ZERO_PATTERN);
    assign w_tens_zero  = (i_seg_tens == ZERO_PATTERN);
    assign w_snap_hunds = w_hunds_zero ? 7'h7F : i_seg_hunds;
    assign w_snap_tens  = (w_hunds_zero && w_tens_zero) ? 7'h7F : i_seg_tens;
`else
    logic w_unused_zero;

    assign w_unused_zero = ^ZERO_PATTERN;
    assign w_snap_hunds  = i_seg_hunds;
    assign w_snap_tens   = i_seg_tens;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_nphase    <= '0;
            r_nslot     <= SLOT_UNITS;
            r_segments  <= '1;
            r_anodes    <= '1;
            r_digit_sel <= '0;
        end else begin
            r_nphase    <= w_nphase_nxt;
            r_nslot     <= w_nslot_nxt;
            r_segments  <= w_seg_nxt;
            r_anodes    <= w_an_nxt;
            r_digit_sel <= w_sel_nxt;
        end
    end

    always_comb begin
        w_nphase_nxt = r_nphase;
        w_nslot_nxt  = r_nslot;
        w_seg_nxt    = r_segments;
        w_an_nxt     = 3'b111;
        w_sel_nxt    = r_digit_sel;

        if (i_enable) begin
            w_sel_nxt = r_nslot;

            if (r_nphase >= DEAD_PHASE) begin
                case (r_nslot)
                    SLOT_TENS:  w_an_nxt = 3'b101;
                    SLOT_HUNDS: w_an_nxt = 3'b011;
                    default:    w_an_nxt = 3'b110;
                endcase
            end

            // Snapshot only at slot start so the bus never changes mid-slot.
            if (r_nphase == '0) begin
                case (r_nslot)
                    SLOT_TENS:  w_seg_nxt = w_snap_tens;
                    SLOT_HUNDS: w_seg_nxt = w_snap_hunds;
                    default:    w_seg_nxt = i_seg_units;
                endcase
            end

            if (r_nphase == LAST_PHASE) begin
                w_nphase_nxt = '0;
                case (r_nslot)
                    SLOT_UNITS: w_nslot_nxt = SLOT_TENS;
                    SLOT_TENS:  w_nslot_nxt = SLOT_HUNDS;
                    default:    w_nslot_nxt = SLOT_UNITS;
                endcase
            end else begin
                w_nphase_nxt = r_nphase + 1'b1;
            end
        end
    end

    assign o_segments  = r_segments;
    assign o_anodes    = r_anodes;
    assign o_digit_sel = r_digit_sel;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with a queue-based scoreboard.
module tb_seven_segment_scanner;

    localparam int unsigned RD = 4;
    localparam int unsigned DC = 1;

    typedef struct packed {
        logic [6:0] seg;
        logic [2:0] an;
        logic [1:0] sel;
    } exp_t;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_enable = 1'b0;
    logic [6:0] i_seg_units = 7'h00;
    logic [6:0] i_seg_tens = 7'h00;
    logic [6:0] i_seg_hunds = 7'h00;
    logic [6:0] o_segments;
    logic [2:0] o_anodes;
    logic [1:0] o_digit_sel;

    exp_t        q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned m_t = 0;
    logic [6:0]  m_snap = 7'h7F;
    logic [1:0]  m_sel = 2'd0;

    seven_segment_scanner #(
        .REFRESH_DIV (RD),
        .DEAD_CYCLES (DC),
        .ZERO_PATTERN(7'b1000000)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_enable   (i_enable),
        .i_seg_units(i_seg_units),
        .i_seg_tens (i_seg_tens),
        .i_seg_hunds(i_seg_hunds),
        .o_segments (o_segments),
        .o_anodes   (o_anodes),
        .o_digit_sel(o_digit_sel)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pick(input int unsigned sl);
        logic [6:0] p;
        case (sl)
            1: p = i_seg_tens;
            2: p = i_seg_hunds;
            default: p = i_seg_units;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (sl == 2 && i_seg_hunds == 7'h40) p = 7'h7F;
        if (sl == 1 && i_seg_hunds == 7'h40 && i_seg_tens == 7'h40) p = 7'h7F;
`endif
        return p;
    endfunction

    task automatic step(input string tag, input logic rst, input logic en);
        exp_t        e;
        exp_t        x;
        int unsigned ph;
        int unsigned sl;
        i_rst    = rst;
        i_enable = en;
        if (rst) begin
            m_t    = 0;
            m_snap = 7'h7F;
            m_sel  = 2'd0;
            e = '{seg: 7'h7F, an: 3'b111, sel: 2'd0};
        end else if (en) begin
            ph = m_t % RD;
            sl = (m_t / RD) % 3;
            if (ph == 0) m_snap = pick(sl);
            m_sel = 2'(sl);
            e.seg = m_snap;
            e.an  = (ph < DC) ? 3'b111 : ~(3'b001 << sl);
            e.sel = m_sel;
            m_t++;
        end else begin
            e = '{seg: m_snap, an: 3'b111, sel: m_sel};
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        x = q.pop_front();
        n_checks++;
        assert (o_segments === x.seg) else begin
            n_fail++;
            $error("FAIL %s seg t=%0d got %h exp %h", tag, m_t, o_segments, x.seg);
        end
        n_checks++;
        assert (o_anodes === x.an) else begin
            n_fail++;
            $error("FAIL %s anodes t=%0d got %b exp %b", tag, m_t, o_anodes, x.an);
        end
        n_checks++;
        assert (o_digit_sel === x.sel) else begin
            n_fail++;
            $error("FAIL %s sel t=%0d got %0d exp %0d", tag, m_t, o_digit_sel, x.sel);
        end
    endtask

    initial begin
        // Reset with arbitrary inputs
        for (int k = 0; k < 3; k++) begin
            i_seg_units = 7'($urandom);
            i_seg_tens  = 7'($urandom);
            i_seg_hunds = 7'($urandom);
            step("reset", 1'b1, 1'b1);
        end

        // Full scan order plus wrap
        i_seg_units = 7'h79;
        i_seg_tens  = 7'h24;
        i_seg_hunds = 7'h30;
        for (int k = 0; k < 14; k++) step("scan", 1'b0, 1'b1);

        // Units changes at phase 2 of the units slot
        i_seg_units = 7'h12;
        for (int k = 0; k < 12; k++) step("midslot", 1'b0, 1'b1);

        // Enable gating entering tens phase 2
        for (int k = 0; k < 12 && (m_t % 12) != 6; k++) step("seek_tens", 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) step("gated", 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) step("resume", 1'b0, 1'b1);

        // Reset during the hundreds slot
        for (int k = 0; k < 12 && (m_t % 12) != 10; k++) step("seek_hunds", 1'b0, 1'b1);
        step("midrst", 1'b1, 1'b1);
        step("midrst", 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) step("restart", 1'b0, 1'b1);

        // Leading-zero patterns
        i_rst = 1'b1;
        step("rst2", 1'b1, 1'b1);
        i_seg_units = 7'h79;
        i_seg_tens  = 7'h40;
        i_seg_hunds = 7'h40;
        for (int k = 0; k < 12; k++) step("lzb", 1'b0, 1'b1);
        i_seg_tens = 7'h24;
        for (int k = 0; k < 12; k++) step("lzb_tens", 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
